// File: rtl/serial_out_card_pkg.sv
// Shared constants for the serial output card: bus widths, control strobe bit
// positions, status register bit layout and TX FSM state encodings.
// Optional feature macro: SERIAL_PARITY_EN adds the PARITY state.
package serial_out_card_pkg;

  localparam int DATAWIDTH  = 16;
  localparam int CTRLWIDTH  = 4;
  localparam int CTRL_MEMWR = 0;
  localparam int CTRL_MEMRD = 1;

  // Status register layout
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_BUSY_BIT  = 3;
  localparam int STAT_LVL_LSB   = 4;
  localparam int STAT_LVL_MSB   = 10;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef SERIAL_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/serial_out_card_byte_fifo.sv
// Byte FIFO for the serial output card; combinational head (dout), registered state.
// Ports: push/din write side, pop/dout read side, full/empty/level status.
// A push while full is accepted only if a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    // Power-of-two depth: pointers wrap by natural overflow.
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/serial_out_card.sv
// Memory-mapped serial TX card: bus writes to IO_ADDR queue bytes, FSM sends 8N1 frames.
// Ports: clk, rst_n, shared data/addr/ctrl bus, tx line (idle high). Status at IO_ADDR+1.
// Writes to a full FIFO are dropped and set a sticky overflow flag. Macro: SERIAL_PARITY_EN.
module serial_out_card
  import serial_out_card_pkg::*;
#(
  parameter logic [15:0] IO_ADDR    = 16'hFFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inout  wire  [DATAWIDTH-1:0] data,
  input  logic [DATAWIDTH-1:0] addr,
  input  logic [CTRLWIDTH-1:0] ctrl,
  output logic                 tx
);
  localparam logic [15:0] STAT_ADDR = IO_ADDR + 16'd1;
  localparam int          CW        = $clog2(BAUD_DIV);
  localparam int          LW        = $clog2(FIFO_DEPTH) + 1;

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
`ifdef SERIAL_PARITY_EN
  logic           par_q, par_d;
`endif

  logic           wr_hit, rd_hit, baud_done, load, push, pop;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [LW-1:0]  fifo_level;
  logic [15:0]    status;
  logic           unused_bits;

  assign wr_hit      = ctrl[CTRL_MEMWR] && (addr == IO_ADDR);
  assign rd_hit      = ctrl[CTRL_MEMRD] && (addr == STAT_ADDR);
  assign unused_bits = ^{ctrl, data[15:8]};
  assign tx          = tx_q;

  // A full FIFO still accepts a byte when the FSM pops on the same edge.
  assign push = wr_hit && (!fifo_full || pop);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status                             = '0;
    status[STAT_EMPTY_BIT]             = fifo_empty;
    status[STAT_FULL_BIT]              = fifo_full;
    status[STAT_OVF_BIT]               = ovf_q;
    status[STAT_BUSY_BIT]              = (state_q != TX_IDLE);
    status[STAT_LVL_MSB:STAT_LVL_LSB]  = 7'(fifo_level);
  end

  assign data = rd_hit ? status : 'z;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
`ifdef SERIAL_PARITY_EN
    par_d     = par_q;
`endif
    load      = 1'b0;
    baud_done = (cnt_q == CW'(BAUD_DIV - 1));
    if (state_q != TX_IDLE) cnt_d = baud_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      TX_IDLE:  load = !fifo_empty;
      TX_START: if (baud_done) begin
        state_d = TX_DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      TX_DATA: if (baud_done) begin
        if (bit_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
          state_d = TX_PARITY;
          tx_d    = par_q;
`else
          state_d = TX_STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef SERIAL_PARITY_EN
      TX_PARITY: if (baud_done) begin
        state_d = TX_STOP;
        tx_d    = 1'b1;
      end
`endif
      TX_STOP: if (baud_done) begin
        // Chain straight into the next START so back-to-back frames have no gap.
        load = !fifo_empty;
        if (fifo_empty) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d = TX_START;
      shift_d = fifo_dout;
      cnt_d   = '0;
      tx_d    = 1'b0;
`ifdef SERIAL_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end

    // Clear on the edge ending a status read; a same-edge overflow wins.
    ovf_d = ovf_q;
    if (rd_hit) ovf_d = 1'b0;
    if (wr_hit && fifo_full && !pop) ovf_d = 1'b1;
  end

  assign pop = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
